cmd_decoder: RTL and testbench
==============================

Name: cmd_decoder

Overview:
- Receive-path counterpart of the command encoder. Parses the incoming byte stream into frames: PREFIX, ADDR, LEN, LEN data bytes, CRC.
- Each frame is buffered whole and its CRC checked. Only good frames are replayed to the addressed destination over a valid/ready byte stream with a one-hot select bus.
- Sits between the UART/link receiver and the per-destination command FIFOs.

Parameters:
- N_DEST, 39: number of destination addresses (0x00..0x26); ADDR >= N_DEST is illegal.
- PREFIX, `PREFIX: frame start byte (value from defines.v).
- MAX_LEN, 255: frame buffer depth in bytes; LEN > MAX_LEN is illegal.
- TIMEOUT_CYC, 50000: inter-byte gap limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe per byte; no backpressure
- out_data  out  8  payload byte to destination
- out_valid  out  1  out_data valid
- out_ready  in  1  destination accepts byte
- out_last  out  1  marks the final payload byte
- out_addr  out  8  destination address of the current frame
- out_sel_bus  out  N_DEST  one-hot destination select; asserted together with out_valid
- busy  out  1  high while in the DELIVER state
- crc_err  out  1  one-cycle pulse: bad CRC, frame discarded
- addr_err  out  1  one-cycle pulse: bad ADDR or LEN, frame discarded
- drop  out  1  one-cycle pulse: rx byte lost because the block was busy

Behaviour:
- Reset: all outputs 0, state HUNT, counters and CRC 0. Reset mid-frame or mid-delivery aborts that frame silently, with no error pulse.
- States:
  - HUNT: on rx_valid with rx_data == PREFIX, go to GET_ADDR. Other bytes are ignored.
  - GET_ADDR: latch ADDR, crc <= ADDR, set bad flag if ADDR >= N_DEST. Go to GET_LEN.
  - GET_LEN: latch LEN, crc <= crc + LEN (mod 256), set bad flag if LEN > MAX_LEN. Go to GET_DATA, or to GET_CRC if LEN == 0.
  - GET_DATA: write the byte to buffer[cnt], crc <= crc + byte, cnt++. After the LEN-th byte, go to GET_CRC.
    - An illegal frame is still consumed byte-for-byte; writes are suppressed once cnt reaches MAX_LEN.
  - GET_CRC: compare the byte with crc.
    - Bad flag set: pulse addr_err, go to HUNT. addr_err takes priority over crc_err.
    - Else mismatch: pulse crc_err, go to HUNT.
    - Else match with LEN == 0: no delivery, go to HUNT.
    - Else: go to DELIVER.
  - DELIVER: stream buffer[0..LEN-1].
    - out_valid rises exactly 2 cycles after the CRC strobe (registered RAM read, show-ahead).
    - A byte transfers when out_valid && out_ready. The next byte is presented the following cycle, so full throughput is 1 byte/clk.
    - out_valid stays high and out_data stays stable while out_ready is low.
    - out_last is high with the byte at index LEN-1. After it transfers, out_valid and out_sel_bus drop next cycle and the state returns to HUNT.
- Checksum: 8-bit wrapping sum of ADDR + LEN + all data bytes; PREFIX is excluded.
- out_sel_bus = 1 << out_addr, gated by out_valid. out_addr holds its value until the next frame.
- rx_valid during DELIVER: the byte is discarded and drop pulses on the following cycle. The parser stays idle; HUNT resumes after delivery.
- A PREFIX-valued byte inside ADDR, LEN, data or CRC is treated as ordinary data; there is no resync mid-frame.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined:
  - A gap counter runs in GET_ADDR..GET_CRC and clears on each rx_valid.
  - Reaching TIMEOUT_CYC returns the state to HUNT and pulses crc_err.
- Not defined: no gap counter, and a partial frame waits indefinitely.

Test Plan:
- PREFIX,0x03,0x02,0x11,0x22,CRC=0x38 with out_ready=1:
  - out_valid begins 2 clk after the CRC strobe.
  - Bytes 0x11 then 0x22 are delivered with out_last on 0x22.
  - out_sel_bus = 1<<3, out_addr = 0x03.
  - No error pulses.
- Same frame with CRC=0x39: crc_err pulses once, out_valid never rises, and the next good frame is delivered.
- PREFIX,0x30,0x01,0xAA,CRC=0xDB: addr_err pulses, no delivery.
- Good frame with out_ready held low for 5 clk on byte 1: out_data stable and out_valid high throughout, no byte lost or duplicated. Garbage 0x00,0x7F sent during delivery pulses drop twice.
- PREFIX,0x09,0x00,CRC=0x09: no delivery, no errors, returns to HUNT.
- With RX_TIMEOUT_EN: PREFIX,0x05 then silence for TIMEOUT_CYC clk gives a crc_err pulse. A following good frame is delivered correctly.
- n_rst asserted mid-DELIVER: outputs 0 immediately, state HUNT after release.

Source files
------------

// File: rtl/cmd_decoder.sv
// cmd_decoder: parses PREFIX/ADDR/LEN/data/CRC frames, buffers and checks each one, and replays good frames to the addressed destination.
// PREFIX defaults to `PREFIX from defines.v. The optional inter-byte timeout is enabled by defining RX_TIMEOUT_EN.
`ifndef PREFIX
`define PREFIX 8'h7E
`endif

module cmd_decoder #(
  parameter int         N_DEST      = 39,
  parameter logic [7:0] PREFIX      = `PREFIX,
  parameter int         MAX_LEN     = 255,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        out_addr,
  output logic [N_DEST-1:0] out_sel_bus,
  output logic              busy,
  output logic              crc_err,
  output logic              addr_err,
  output logic              drop
);

  // state    | meaning
  // S_HUNT   | wait for PREFIX, ignore everything else
  // S_ADDR   | next byte is the destination address
  // S_LEN    | next byte is the payload length
  // S_DATA   | buffering payload bytes
  // S_CRC    | next byte is the checksum; decide deliver/discard
  // S_DELIVER| replay buffer to destination, rx bytes are dropped
  typedef enum logic [2:0] {
    S_HUNT, S_ADDR, S_LEN, S_DATA, S_CRC, S_DELIVER
  } state_t;

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] N_DEST9   = 9'(N_DEST);
  localparam logic [8:0] MAX_LEN9  = 9'(MAX_LEN);

  state_t            r_state;
  logic [7:0]        r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [7:0]        r_crc;
  logic              r_bad;
  logic              r_prime;
  logic [7:0]        r_rd_idx;
  logic [7:0]        r_ram_q;
  logic [7:0]        r_out_addr;
  logic              r_out_valid;
  logic              r_out_last;
  logic [N_DEST-1:0] r_sel;
  logic              r_busy;
  logic              r_crc_err;
  logic              r_addr_err;
  logic              r_drop;
  logic [7:0]        r_mem [0:MAX_LEN-1];

  logic              w_xfer;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_timeout;
  logic [N_DEST-1:0] w_onehot;

  assign w_xfer   = r_out_valid && out_ready;
  assign w_wr_en  = (r_state == S_DATA) && rx_valid && ({1'b0, r_cnt} < MAX_LEN9);
  assign w_rd_en  = (r_state == S_DELIVER) && (r_prime || (w_xfer && !r_out_last));
  assign w_onehot = {{(N_DEST-1){1'b0}}, 1'b1} << r_out_addr;

`ifdef RX_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  logic [GW-1:0] r_gap;
  logic          w_parse;

  assign w_parse   = (r_state == S_ADDR) || (r_state == S_LEN) ||
                     (r_state == S_DATA) || (r_state == S_CRC);
  assign w_timeout = w_parse && !rx_valid && (r_gap == GW'(1));

  // Down-counter reloads on every received byte; expiring while a frame is open aborts it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_gap <= '0;
    end else if (rx_valid) begin
      r_gap <= GW'(TIMEOUT_CYC);
    end else if (r_gap != '0) begin
      r_gap <= r_gap - GW'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_cnt[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ram_q <= 8'h00;
    end else if (w_rd_en) begin
      r_ram_q <= r_mem[r_rd_idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_HUNT;
      r_addr      <= 8'h00;
      r_len       <= 8'h00;
      r_cnt       <= 8'h00;
      r_crc       <= 8'h00;
      r_bad       <= 1'b0;
      r_prime     <= 1'b0;
      r_rd_idx    <= 8'h00;
      r_out_addr  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_crc_err   <= 1'b0;
      r_addr_err  <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_crc_err  <= 1'b0;
      r_addr_err <= 1'b0;
      r_drop     <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (rx_valid && (rx_data == PREFIX)) begin
            r_bad   <= 1'b0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr  <= rx_data;
            r_crc   <= rx_data;
            r_bad   <= ({1'b0, rx_data} >= N_DEST9);
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            r_len <= rx_data;
            r_crc <= r_crc + rx_data;
            r_cnt <= 8'h00;
            if ({1'b0, rx_data} > MAX_LEN9) begin
              r_bad <= 1'b1;
            end
            r_state <= (rx_data == 8'h00) ? S_CRC : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_crc <= r_crc + rx_data;
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == r_len - 8'd1) begin
              r_state <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (rx_valid) begin
            r_state <= S_HUNT;
            if (r_bad) begin
              r_addr_err <= 1'b1;
            end else if (rx_data != r_crc) begin
              r_crc_err <= 1'b1;
            end else if (r_len != 8'h00) begin
              r_state    <= S_DELIVER;
              r_prime    <= 1'b1;
              r_rd_idx   <= 8'h00;
              r_busy     <= 1'b1;
              r_out_addr <= r_addr;
            end
          end
        end
        S_DELIVER: begin
          if (rx_valid) begin
            r_drop <= 1'b1;
          end
          // First cycle only launches the read of byte 0; valid follows with the data.
          if (r_prime) begin
            r_prime     <= 1'b0;
            r_out_valid <= 1'b1;
            r_sel       <= w_onehot;
            r_rd_idx    <= 8'd1;
            r_out_last  <= (r_len == 8'd1);
          end else if (w_xfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_sel       <= '0;
              r_busy      <= 1'b0;
              r_state     <= S_HUNT;
            end else begin
              r_rd_idx   <= r_rd_idx + 8'd1;
              r_out_last <= (r_rd_idx == r_len - 8'd1);
            end
          end
        end
        default: r_state <= S_HUNT;
      endcase
      if (w_timeout) begin
        r_state   <= S_HUNT;
        r_crc_err <= 1'b1;
      end
    end
  end

  assign out_data    = r_ram_q;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_addr    = r_out_addr;
  assign out_sel_bus = r_sel;
  assign busy        = r_busy;
  assign crc_err     = r_crc_err;
  assign addr_err    = r_addr_err;
  assign drop        = r_drop;

endmodule

// File: tb/tb_cmd_decoder.sv
// Self-checking bench for cmd_decoder: table of frames with hand-computed checksums and outcomes,
// plus hand-written sequences for backpressure/drop, reset mid-delivery and the optional timeout.
module tb_cmd_decoder;

  localparam int         ND  = 39;
  localparam logic [7:0] PFX = 8'h7E;
  localparam int         TO  = 200;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [7:0]    out_addr;
  logic [ND-1:0] out_sel_bus;
  logic          busy;
  logic          crc_err;
  logic          addr_err;
  logic          drop;

  cmd_decoder #(.N_DEST(ND), .PREFIX(PFX), .MAX_LEN(255), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_addr(out_addr), .out_sel_bus(out_sel_bus),
    .busy(busy), .crc_err(crc_err), .addr_err(addr_err), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int n_crc = 0, n_aerr = 0, n_drop = 0, n_vcyc = 0, n_selbad = 0;
  logic [7:0]    q_data[$];
  logic          q_last[$];
  logic [ND-1:0] q_sel[$];

  always @(negedge clk) begin
    if (crc_err)  n_crc++;
    if (addr_err) n_aerr++;
    if (drop)     n_drop++;
    if (out_valid) n_vcyc++;
    if (!out_valid && out_sel_bus != '0) n_selbad++;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
      q_sel.push_back(out_sel_bus);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]      addr;
    logic [7:0]      len;
    logic [3:0][7:0] data;
    logic [7:0]      crc;
    bit              del;
    bit              cerr;
    bit              aerr;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] l,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3,
                              input logic [7:0] c, input bit del, input bit ce, input bit ae);
    vec_t v;
    v.addr = a; v.len = l; v.data = {d3, d2, d1, d0}; v.crc = c;
    v.del = del; v.cerr = ce; v.aerr = ae;
    return v;
  endfunction

  task automatic send_frame(input vec_t v);
    send(PFX);
    send(v.addr);
    send(v.len);
    for (int i = 0; i < int'(v.len); i++) send(v.data[i]);
    send(v.crc);
  endtask

  task automatic wait_done(input string name, input int nbytes);
    int k;
    k = 0;
    while (!(q_data.size() >= nbytes && !out_valid) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_in_time"}, 64'(k < 60), 64'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int c0, a0, v0;
    string nm;
    logic [ND-1:0] esel;
    nm = $sformatf("v%0d", idx);
    send(8'h55);
    q_data.delete(); q_last.delete(); q_sel.delete();
    c0 = n_crc; a0 = n_aerr; v0 = n_vcyc;
    send_frame(v);
    if (v.del) begin
      esel = '0;
      esel[v.addr] = 1'b1;
      @(negedge clk);
      chk({nm, "_valid_lat1"}, 64'(out_valid), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      chk({nm, "_valid_lat2"}, 64'(out_valid), 64'd1);
      wait_done(nm, int'(v.len));
      chk({nm, "_nbytes"}, 64'(q_data.size()), 64'(v.len));
      for (int i = 0; i < q_data.size() && i < int'(v.len); i++) begin
        chk($sformatf("%s_byte%0d", nm, i), 64'(q_data[i]), 64'(v.data[i]));
        chk($sformatf("%s_last%0d", nm, i), 64'(q_last[i]), 64'(i == int'(v.len) - 1));
        chk($sformatf("%s_sel%0d", nm, i), 64'(q_sel[i]), 64'(esel));
      end
      chk({nm, "_addr"}, 64'(out_addr), 64'(v.addr));
      chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    end else begin
      repeat (4) @(negedge clk);
      chk({nm, "_no_valid"}, 64'(n_vcyc - v0), 64'd0);
    end
    chk({nm, "_crc_err"}, 64'(n_crc - c0), 64'(v.cerr));
    chk({nm, "_addr_err"}, 64'(n_aerr - a0), 64'(v.aerr));
  endtask

  vec_t tbl[8];
  vec_t good;

  initial begin
    tbl[0] = mk(8'h03, 8'd2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h39, 0, 1, 0);
    tbl[1] = mk(8'h03, 8'd2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h38, 1, 0, 0);
    tbl[2] = mk(8'h30, 8'd1, 8'hAA, 8'h00, 8'h00, 8'h00, 8'hDB, 0, 0, 1);
    tbl[3] = mk(8'h09, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 0, 0, 0);
    tbl[4] = mk(8'h26, 8'd1, 8'h7E, 8'h00, 8'h00, 8'h00, 8'hA5, 1, 0, 0);
    tbl[5] = mk(8'h27, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h27, 0, 0, 1);
    tbl[6] = mk(8'h00, 8'd3, 8'h01, 8'h02, 8'h03, 8'h00, 8'h09, 1, 0, 0);
    tbl[7] = mk(8'h15, 8'd4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h15, 1, 0, 0);
    good   = tbl[1];

    #23;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sel", 64'(out_sel_bus), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_pulses", 64'({crc_err, addr_err, drop, out_last}), 64'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #2;

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // Backpressure on byte 1 with garbage arriving during delivery.
    begin
      vec_t s;
      int d0, unstable, k;
      s = mk(8'h05, 8'd3, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h29, 1, 0, 0);
      q_data.delete(); q_last.delete(); q_sel.delete();
      d0 = n_drop;
      unstable = 0;
      send_frame(s);
      k = 0;
      while (!out_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("stall_valid_seen", 64'(out_valid), 64'd1);
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        rx_valid = (i == 0) || (i == 2);
        rx_data  = (i == 0) ? 8'h00 : 8'h7F;
        @(negedge clk);
        if (!out_valid || out_data !== 8'h0B || !busy) unstable++;
        @(posedge clk);
        #2;
      end
      rx_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stall_stable", 64'(unstable), 64'd0);
      wait_done("stall", 3);
      chk("stall_nbytes", 64'(q_data.size()), 64'd3);
      if (q_data.size() == 3) begin
        chk("stall_b0", 64'(q_data[0]), 64'h0A);
        chk("stall_b1", 64'(q_data[1]), 64'h0B);
        chk("stall_b2", 64'(q_data[2]), 64'h0C);
        chk("stall_last", 64'({q_last[0], q_last[1], q_last[2]}), 64'b001);
      end
      chk("stall_drops", 64'(n_drop - d0), 64'd2);
    end

    // Reset asserted while a frame is being delivered.
    begin
      int c0, a0, k;
      c0 = n_crc; a0 = n_aerr;
      out_ready = 1'b0;
      send_frame(tbl[7]);
      k = 0;
      while (!out_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("rstmid_valid_seen", 64'(out_valid), 64'd1);
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      chk("rstmid_valid", 64'(out_valid), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_sel", 64'(out_sel_bus), 64'd0);
      chk("rstmid_data", 64'(out_data), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      n_rst = 1'b1;
      @(posedge clk);
      #2;
      chk("rstmid_no_err", 64'((n_crc - c0) + (n_aerr - a0)), 64'd0);
      run_vec(10, good);
    end

`ifdef RX_TIMEOUT_EN
    begin
      int k;
      send(PFX);
      send(8'h05);
      k = 0;
      while (k < TO + 10) begin
        @(negedge clk);
        if (crc_err) break;
        k++;
      end
      chk("timeout_cycles", 64'(k), 64'(TO));
      @(posedge clk);
      #2;
      run_vec(11, good);
    end
`endif

    chk("sel_gated", 64'(n_selbad), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
